// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the counted right-shift sequencer.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (adds the rotate fill mode).
package shift_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  // FSM encoding; 2'b11 is unused and steers back to IDLE
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'b00;
  localparam state_t SHIFT = 2'b01;
  localparam state_t FIN   = 2'b10;

  // Source of the bit entering the MSB on each shift
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_MSB  = 2'd1,
    FILL_ROT  = 2'd2
  } fill_t;

  // Rotate wins over arithmetic when both are requested
  function automatic fill_t fill_sel(input logic arith, input logic rot);
    if (rot)        return FILL_ROT;
    else if (arith) return FILL_MSB;
    else            return FILL_ZERO;
  endfunction

endpackage

// File: rtl/shift_reg_stage.sv
// WIDTH-bit right-shift register: parallel load, single-bit shift with
// selectable MSB fill, async active-low clear.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (enables the rotate fill path).
module shift_reg_stage
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shen,
  input  fill_t            fill,
  output logic [WIDTH-1:0] q
);

  logic fbit;

  // Bit shifted into the MSB
  always_comb begin
    fbit = 1'b0;
    case (fill)
      FILL_MSB: fbit = q[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
      FILL_ROT: fbit = q[0];
`endif
      default:  fbit = 1'b0;
    endcase
  end

  // Load has priority over shift; bit 0 falls off the bottom
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    q <= '0;
    else if (load) q <= din;
    else if (shen) q <= {fbit, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for counted, handshaked right shifts: START loads operand and
// count, one shift per clock, DONE pulses for one cycle at completion.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (adds rot port, unclamped rotate).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] amt,
  input  logic             arith,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WCLAMP = CNT_W'(WIDTH);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, eff_cnt;
  fill_t            mode, req_mode;
  logic             load, shen;

  assign load = (state == IDLE) && start;
  assign shen = (state == SHIFT);

  // Effective count and fill mode for a new request
  always_comb begin
    eff_cnt  = (amt > WCLAMP) ? WCLAMP : amt;
    req_mode = fill_sel(arith, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rot) eff_cnt = amt;
    req_mode = fill_sel(arith, rot);
`endif
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (eff_cnt == '0) ? FIN : SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, counter, mode flags and registered status outputs
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= FILL_ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        cnt  <= eff_cnt;
        mode <= req_mode;
      end else if (shen) begin
        cnt  <= cnt - CNT_W'(1);
      end
      busy <= (nxt != IDLE);
      done <= (nxt == FIN);
    end
  end

  shift_reg_stage #(.WIDTH(WIDTH)) u_sreg (
    .clk   (clk),
    .clr_n (init_n),
    .load  (load),
    .din   (din),
    .shen  (shen),
    .fill  (mode),
    .q     (out)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=4, CNT_W=3).
// Rotate cases run when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             init_n;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [CNT_W-1:0] amt;
  logic             arith;
  logic             rot;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .init_n (init_n),
    .start  (start),
    .din    (din),
    .amt    (amt),
    .arith  (arith),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot    (rot),
`endif
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for DONE; reports shifts taken (-1 on timeout)
  task automatic run_op(input logic [3:0] d, input logic [2:0] a, input logic ar,
                        input logic ro, output int edges);
    din = d; amt = a; arith = ar; rot = ro; start = 1'b1;
    tick;
    start = 1'b0;
    din = 4'bxxxx; amt = 3'bxxx; arith = 1'bx;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    edges = 0;
    while (!done && edges < 20) begin
      tick;
      edges++;
    end
    if (!done) edges = -1;
  endtask

  int e;

  initial begin
    init_n = 1'b0; start = 1'b0; din = '0; amt = '0; arith = 1'b0; rot = 1'b0;
    tick; tick;
    chk("rst_out",  {28'd0, out}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    init_n = 1'b1;
    tick;

    // Logical shift, stepped cycle by cycle
    din = 4'b1000; amt = 3'd2; arith = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("log_e0_out",  {28'd0, out}, 32'b1000);
    chk("log_e0_done", {31'd0, done}, 32'd0);
    tick;
    chk("log_e1_out",  {28'd0, out}, 32'b0100);
    chk("log_e1_busy", {31'd0, busy}, 32'd1);
    chk("log_e1_done", {31'd0, done}, 32'd0);
    tick;
    chk("log_e2_out",  {28'd0, out}, 32'b0010);
    chk("log_e2_done", {31'd0, done}, 32'd1);
    chk("log_e2_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("log_e3_done", {31'd0, done}, 32'd0);
    chk("log_e3_busy", {31'd0, busy}, 32'd0);
    tick; tick;
    chk("log_hold_out", {28'd0, out}, 32'b0010);

    // Arithmetic shift
    run_op(4'b1000, 3'd3, 1'b1, 1'b0, e);
    chk("ari_edges", e, 32'd3);
    chk("ari_out", {28'd0, out}, 32'b1111);
    tick;

    // Clamp: AMT=7 becomes 4 shifts
    run_op(4'b1111, 3'd7, 1'b0, 1'b0, e);
    chk("clamp_edges", e, 32'd4);
    chk("clamp_out", {28'd0, out}, 32'b0000);
    tick;
    chk("clamp_idle_busy", {31'd0, busy}, 32'd0);

    // Zero amount: DONE right after the START edge
    run_op(4'b1011, 3'd0, 1'b0, 1'b0, e);
    chk("zero_edges", e, 32'd0);
    chk("zero_out", {28'd0, out}, 32'b1011);
    tick;
    chk("zero_busy_after", {31'd0, busy}, 32'd0);
    chk("zero_done_after", {31'd0, done}, 32'd0);

    // START held through SHIFT and FIN is ignored
    din = 4'b1100; amt = 3'd2; arith = 1'b0; start = 1'b1;
    tick;
    din = 4'b0101; amt = 3'd1; arith = 1'b1;
    tick;
    chk("col_e1_out", {28'd0, out}, 32'b0110);
    tick;
    chk("col_e2_done", {31'd0, done}, 32'd1);
    chk("col_e2_out", {28'd0, out}, 32'b0011);
    tick;
    start = 1'b0;
    chk("col_e3_busy", {31'd0, busy}, 32'd0);
    chk("col_e3_done", {31'd0, done}, 32'd0);
    chk("col_e3_out", {28'd0, out}, 32'b0011);
    tick;
    chk("col_e4_busy", {31'd0, busy}, 32'd0);
    chk("col_e4_out", {28'd0, out}, 32'b0011);

    // Reset mid-SHIFT takes effect without a clock edge
    din = 4'b1111; amt = 3'd4; arith = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    #2 init_n = 1'b0;
    #1;
    chk("midrst_out",  {28'd0, out}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    #1 init_n = 1'b1;
    tick;
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    run_op(4'b0110, 3'd1, 1'b0, 1'b0, e);
    chk("post_rst_edges", e, 32'd1);
    chk("post_rst_out", {28'd0, out}, 32'b0011);
    tick;

    // Reset while idle clears a held result immediately
    #2 init_n = 1'b0;
    #1;
    chk("idle_rst_out", {28'd0, out}, 32'h0);
    #1 init_n = 1'b1;
    tick;

`ifdef SHIFT_SEQ_ROTATE_EN
    run_op(4'b0001, 3'd1, 1'b0, 1'b1, e);
    chk("rot1_edges", e, 32'd1);
    chk("rot1_out", {28'd0, out}, 32'b1000);
    tick;
    run_op(4'b0011, 3'd6, 1'b1, 1'b1, e);
    chk("rot6_edges", e, 32'd6);
    chk("rot6_out", {28'd0, out}, 32'b1100);
    tick;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller that sequences a WIDTH-bit right-shift datapath. A requester loads an operand and shift amount with a START pulse; the block performs one single-bit right shift per clock, then pulses DONE. The result is held until the next operation. It sits between control logic and the shift register, with the register owned internally, and replaces free-running shifting with counted, handshaked operations.

## Interface
- WIDTH, 4, datapath width in bits (≥2)
- CNT_W, 3, width of the shift-amount field; must hold WIDTH
- CLK  in  1  rising-edge clock
- INIT_N  in  1  asynchronous active-low reset
- START  in  1  request; sampled only in IDLE
- DIN  in  WIDTH  operand, captured with START
- AMT  in  CNT_W  shift amount, captured with START
- ARITH  in  1  captured with START; 1 = fill with operand MSB, 0 = fill with 0
- ROT  in  1  rotate select; present only with SHIFT_SEQ_ROTATE_EN
- OUT  out  WIDTH  shift register contents
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE
  - SHIFT
  - FIN
- IDLE behaviour:
  - START=1 at an edge captures DIN into the register, the effective count into CNT, and ARITH/ROT into mode flags.
  - If the effective count is non-zero, go to SHIFT. If it is 0, go to FIN.
  - START=0: OUT, BUSY and DONE hold.
- Effective count:
  - min(AMT, WIDTH) for logical and arithmetic shifts. AMT>WIDTH gives an all-fill result.
  - Unclamped AMT for rotate.
- SHIFT, each edge:
  - Register shifts right by 1. Bit 0 is discarded.
  - New MSB is 0 (logical), the current MSB (arithmetic), or the old bit 0 (rotate).
  - CNT decrements.
  - When the shift just taken was the last one (CNT==1 before the edge), go to FIN.
- FIN: DONE=1 for exactly one cycle, then return to IDLE unconditionally.
- START in SHIFT or FIN is ignored, with no queuing. START in the same cycle DONE is high is ignored. The requester must wait for IDLE (BUSY=0, DONE=0).
- BUSY=1 in SHIFT and in FIN.
- OUT is the live register value. It is final when DONE=1 and stays stable in IDLE.
- DIN, AMT and ARITH are don't-care except at the START edge.
- Reset:
  - INIT_N low forces state=IDLE, OUT=0, CNT=0, BUSY=0, DONE=0 and clears the mode flags, asynchronously, in any state.
  - Reset mid-operation aborts the operation; the partial result is lost.
  - The first START after INIT_N deasserts is honoured normally.

## Timing
- START sampled at edge 0.
- Operand is visible on OUT after edge 0.
- Shifts occur at edges 1..N, where N is the effective count.
- DONE high during the cycle after edge N, i.e. the cycle after edge 0 when N=0.
- IDLE after edge N+1.
- Issue interval: N+2 cycles minimum.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined:
  - ROT port exists. ROT=1 selects rotate and overrides ARITH.
  - AMT is not clamped, so up to 2^CNT_W−1 single-bit rotates are performed.
- Macro undefined:
  - No ROT port and no rotate path.
  - Only logical and arithmetic shifts; AMT is always clamped to WIDTH.

## Structure
- Package shift_seq_pkg contains:
  - State typedef: IDLE=2'b00, SHIFT=2'b01, FIN=2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
  - Default-width constants.
  - Fill-mode enum (FILL_ZERO, FILL_MSB, FILL_ROT).
- Sub-module shift_reg_stage:
  - WIDTH-bit register with load, shift-enable and fill-mode inputs, plus async active-low clear.
  - The sequencer holds only the FSM, the counter and the mode flags.

## Test plan
All cases use WIDTH=4, CNT_W=3.
- Reset: INIT_N=0 mid-idle → OUT=0000, BUSY=0, DONE=0 immediately, without waiting for a clock edge.
- Logical: DIN=1000, AMT=2, ARITH=0 → BUSY for 2 shift cycles, then DONE; OUT=0010 while DONE=1.
- Arithmetic and clamp:
  - DIN=1000, AMT=3, ARITH=1 → OUT=1111.
  - DIN=1111, AMT=7, ARITH=0 → 4 shifts, OUT=0000, DONE 5 cycles after START.
- Zero amount: DIN=1011, AMT=0 → DONE in the cycle after START, OUT=1011, BUSY high for that one cycle only.
- Collisions:
  - START pulsed during SHIFT and during DONE → ignored; OUT matches the first operation.
  - INIT_N pulsed mid-SHIFT → immediate IDLE/OUT=0000; next START DIN=0110, AMT=1 → OUT=0011.
- Rotate (macro defined): ROT=1, DIN=0001, AMT=1 → OUT=1000. ROT=1, DIN=0011, AMT=6 → OUT=1100.
